// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES definitions for the iterative encrypt/decrypt engines:
//   - bit-permutation tables IP, FP, E, P, PC1, PC2 (DES 1-based, MSB-first)
//   - S-box contents S1..S8 (row = outer bits, column = inner four bits)
//   - decrypt key-schedule right-rotation amounts SH_DEC[1:16]
//   - engine state encoding
//   - permutation helpers. DES bit n of a w-bit vector is vector[w-n].
// -----------------------------------------------------------------------------
package des_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Parity bits 8,16,..,64 never appear here, so they are dropped.
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Round 1 of decryption needs K16 = PC2(C0D0), so no rotation; the rest
  // undo the encrypt left shifts in reverse order.
  localparam int SH_DEC [1:16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int SBOX_T [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  // Row is the outer bit pair {b6,b1}, column the inner bits b5..b2.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [5:0] a);
    return 4'(SBOX_T[n][{a[5], a[0], a[4:1]}]);
  endfunction

  function automatic logic [1:0] sh_dec(input logic [4:0] rnd);
    logic [1:0] sh;
    sh = 2'd0;
    for (int i = 1; i <= 16; i++) begin
      if (rnd == 5'(i)) sh = 2'(SH_DEC[i]);
    end
    return sh;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] sh);
    case (sh)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_f.sv
// -----------------------------------------------------------------------------
// des_f
// DES round function f(R,K), purely combinational; shared by the encrypt and
// decrypt engines.
//   r [31:0] : right half, DES bit 1 = r[31]
//   k [47:0] : round subkey, DES bit 1 = k[47]
//   f [31:0] : P(S1..S8(E(r) ^ k))
// -----------------------------------------------------------------------------
module des_f import des_pkg::*; (
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  logic [47:0] x;
  logic [31:0] s;

  assign x = des_e(r) ^ k;

  // Chunk 1 (MSBs) feeds S1, chunk 8 feeds S8.
  S1_ROM u_s1 (.addr(x[47:42]), .data(s[31:28]));
  S2_ROM u_s2 (.addr(x[41:36]), .data(s[27:24]));
  S3_ROM u_s3 (.addr(x[35:30]), .data(s[23:20]));
  S4_ROM u_s4 (.addr(x[29:24]), .data(s[19:16]));
  S5_ROM u_s5 (.addr(x[23:18]), .data(s[15:12]));
  S6_ROM u_s6 (.addr(x[17:12]), .data(s[11:8]));
  S7_ROM u_s7 (.addr(x[11:6]),  .data(s[7:4]));
  S8_ROM u_s8 (.addr(x[5:0]),   .data(s[3:0]));

  assign f = des_p(s);

endmodule

// File: rtl/des_sbox_rom.sv
// -----------------------------------------------------------------------------
// S1_ROM .. S8_ROM
// Combinational DES S-boxes, one module per box so each engine instantiates
// exactly the tables it needs.
//   addr [5:0] : six-bit chunk, addr[5] = DES bit 1 of the chunk
//   data [3:0] : four-bit substitution, MSB first
// -----------------------------------------------------------------------------
module S1_ROM import des_pkg::*; (
  input  logic [5:0] addr,
  output logic [3:0] data
);
  assign data = sbox_lookup(3'd0, addr);
endmodule

module S2_ROM import des_pkg::*; (
  input  logic [5:0] addr,
  output logic [3:0] data
);
  assign data = sbox_lookup(3'd1, addr);
endmodule

module S3_ROM import des_pkg::*; (
  input  logic [5:0] addr,
  output logic [3:0] data
);
  assign data = sbox_lookup(3'd2, addr);
endmodule

module S4_ROM import des_pkg::*; (
  input  logic [5:0] addr,
  output logic [3:0] data
);
  assign data = sbox_lookup(3'd3, addr);
endmodule

module S5_ROM import des_pkg::*; (
  input  logic [5:0] addr,
  output logic [3:0] data
);
  assign data = sbox_lookup(3'd4, addr);
endmodule

module S6_ROM import des_pkg::*; (
  input  logic [5:0] addr,
  output logic [3:0] data
);
  assign data = sbox_lookup(3'd5, addr);
endmodule

module S7_ROM import des_pkg::*; (
  input  logic [5:0] addr,
  output logic [3:0] data
);
  assign data = sbox_lookup(3'd6, addr);
endmodule

module S8_ROM import des_pkg::*; (
  input  logic [5:0] addr,
  output logic [3:0] data
);
  assign data = sbox_lookup(3'd7, addr);
endmodule

// File: rtl/des_decrypt_iter.sv
// -----------------------------------------------------------------------------
// des_decrypt_iter
// Iterative DES decryption: one Feistel round per clock, 16 rounds per block,
// subkeys K16..K1 generated on the fly by right-rotating C and D.
// One block in flight; accept -> 16 rounds -> present plaintext -> handshake.
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   in_valid/ready : ciphertext/key ingress, DES bit 1 = bit 63
//   in_data [63:0] : ciphertext
//   in_key  [63:0] : key, parity bits ignored
//   out_valid/ready: plaintext egress
//   out_data[63:0] : plaintext, held stable while out_valid is high
// -----------------------------------------------------------------------------
module des_decrypt_iter import des_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  state_t      state;
  logic [4:0]  round;
  logic [31:0] l, r;
  logic [55:0] cd;
  logic [55:0] cd_next;
  logic [47:0] subkey;
  logic [31:0] f_out;
  logic [1:0]  shift;

  // NOTE: every signal driven in always_comb gets a value on every path;
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    shift   = sh_dec(round);
    cd_next = {rotr28(cd[55:28], shift), rotr28(cd[27:0], shift)};
    subkey  = des_pc2(cd_next);
  end

  des_f u_f (
    .r (r),
    .k (subkey),
    .f (f_out)
  );

  // NOTE: state registers use non-blocking assignments so every right-hand
  // side sees pre-edge values; l <= r and r <= l ^ f rely on that.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      round     <= '0;
      l         <= '0;
      r         <= '0;
      cd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            {l, r}   <= des_ip(in_data);
            cd       <= des_pc1(in_key);
            round    <= 5'd1;
            in_ready <= 1'b0;
            state    <= ROUND;
          end
        end

        ROUND: begin
          cd <= cd_next;
          l  <= r;
          r  <= l ^ f_out;
          if (round == 5'd16) begin
            round <= '0;
            state <= DONE;
          end else begin
            round <= round + 5'd1;
          end
        end

        DONE: begin
          // First DONE cycle registers the swapped, FP-permuted result;
          // after that the output is held until the handshake.
          if (!out_valid) begin
            out_data  <= des_fp({r, l});
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_des_decrypt_iter
// Directed known-answer vectors, handshake timing sequences, mid-block reset,
// and a round trip through an in-bench DES encryption model.
// -----------------------------------------------------------------------------
module tb_des_decrypt_iter;
  import des_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_decrypt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    logic [63:0] key;
    logic [63:0] cipher;
    logic [63:0] plain;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference encryption model ----------------
  function automatic logic [31:0] m_f(input logic [31:0] rv, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = rv[5'(32 - E_T[i])];
    x = x ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      b = 6'(x >> (6 * (7 - j)));
      s = {s[27:0], 4'(SBOX_T[3'(j)][{b[5], b[0], b[4:1]}])};
    end
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] m_encrypt(input logic [63:0] p, input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    logic [63:0] t;
    logic [31:0] l, r, tmp;
    int          nsh;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_T[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 64; i++) t[6'(63 - i)] = p[6'(64 - IP_T[i])];
    l = t[63:32];
    r = t[31:0];
    for (int rr = 1; rr <= 16; rr++) begin
      nsh = (rr == 1 || rr == 2 || rr == 9 || rr == 16) ? 1 : 2;
      for (int s = 0; s < nsh; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
      tmp = r;
      r   = l ^ m_f(r, k);
      l   = tmp;
    end
    t = {r, l};
    for (int i = 0; i < 64; i++) p[6'(63 - i)] = t[6'(64 - FP_T[i])];
    return p;
  endfunction

  // ---------------- handshake helpers ----------------
  // Returns at the negedge following the accepting edge, with in_valid
  // dropped and the inputs scrambled.
  task automatic send(input logic [63:0] key, input logic [63:0] cipher);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_key   = key;
    in_data  = cipher;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept timeout in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_key   = {$urandom, $urandom};
  endtask

  // Counts clock edges after the accepting edge until out_valid is seen.
  task automatic wait_out(output int cycles, output logic ready_seen);
    cycles     = 0;
    ready_seen = 1'b0;
    do begin
      @(negedge clk);
      cycles++;
      if (in_ready) ready_seen = 1'b1;
    end while (!out_valid && cycles < 100);
    if (!out_valid) check("out_valid timeout", 64'(out_valid), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cycles;
    int          n;
    logic        ready_seen;
    logic        pending;
    logic        pulsed;
    logic [63:0] key, plain, cipher;

    vecs[0] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
    vecs[1] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};
    vecs[2] = '{64'h0F339333EB6C0C72, 64'h0000000000000000, 64'h8787878787878787};
    vecs[3] = '{64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};
    vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", out_data, 64'd0);
    rst = 1'b0;

    // Known-answer vectors with out_ready tied high.
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].key, vecs[v].cipher);
      wait_out(cycles, ready_seen);
      check($sformatf("vec%0d latency", v), 64'(cycles), 64'd17);
      check($sformatf("vec%0d out_data", v), out_data, vecs[v].plain);
      check($sformatf("vec%0d in_ready busy", v), 64'(ready_seen), 64'd0);
      @(negedge clk);
      check($sformatf("vec%0d out_valid one cycle", v), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d in_ready after", v), 64'(in_ready), 64'd1);
    end

    // Backpressure: out_ready low for 10 cycles after out_valid.
    out_ready = 1'b0;
    send(vecs[1].key, vecs[1].cipher);
    wait_out(cycles, ready_seen);
    check("bp out_data", out_data, 64'h8787878787878787);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp hold out_valid %0d", i), 64'(out_valid), 64'd1);
      check($sformatf("bp hold out_data %0d", i), out_data, 64'h8787878787878787);
      check($sformatf("bp hold in_ready %0d", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release out_valid", 64'(out_valid), 64'd0);
    check("bp release in_ready", 64'(in_ready), 64'd1);

    // Second vector offered during ROUND: taken only after the first handoff.
    send(vecs[0].key, vecs[0].cipher);
    in_valid = 1'b1;
    in_key   = vecs[1].key;
    in_data  = vecs[1].cipher;
    wait_out(cycles, ready_seen);
    check("held first latency", 64'(cycles), 64'd17);
    check("held first out_data", out_data, vecs[0].plain);
    check("held no early accept", 64'(ready_seen), 64'd0);
    n       = 0;
    pending = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (pending) begin
        in_valid = 1'b0;
        pending  = 1'b0;
      end
      if (in_valid && in_ready) pending = 1'b1;
    end while (!out_valid && n < 100);
    check("held second spacing", 64'(n), 64'd19);
    check("held second out_data", out_data, vecs[1].plain);
    in_valid = 1'b0;
    @(negedge clk);

    // Reset in round 8 discards the block.
    send(vecs[0].key, vecs[0].cipher);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst out_data", out_data, 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    rst    = 1'b0;
    pulsed = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) pulsed = 1'b1;
    end
    check("midrst no pulse", 64'(pulsed), 64'd0);
    send(vecs[0].key, vecs[0].cipher);
    wait_out(cycles, ready_seen);
    check("post-rst latency", 64'(cycles), 64'd17);
    check("post-rst out_data", out_data, vecs[0].plain);

    // Round trip against the encryption model.
    for (int i = 0; i < 1000; i++) begin
      key    = {$urandom, $urandom};
      plain  = {$urandom, $urandom};
      cipher = m_encrypt(plain, key);
      send(key, cipher);
      wait_out(cycles, ready_seen);
      check($sformatf("roundtrip %0d key %h", i, key), out_data, plain);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
